fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the hazard unit and the decode stage.
- Owns the PC and talks to a variable-latency instruction memory through a request/valid handshake.
- Obeys PC_Write, IF_ID_Write and Flush from the hazard unit.
- Computes the redirect target from decode-stage Jump/PCSource information.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants for the fetch stage: jump encodings, fetch FSM
// state encoding and the bubble instruction word.
package fetch_stage_pkg;

  localparam logic [1:0] JUMP_NONE = 2'd0;
  localparam logic [1:0] JUMP_J    = 2'd1;
  localparam logic [1:0] JUMP_JR   = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: write-enable, flush-to-bubble, synchronous
// active-low reset. A bubble keeps the previous PC+4 and only kills the word.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write_en,
  input  logic        flush,
  input  logic        load_valid,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Flush beats a stall; a write with nothing delivered becomes a bubble.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush || (write_en && !load_valid)) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (write_en) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a one-outstanding-request
// instruction memory handshake and feeds the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic        Flush,
  input  logic        PCSource,
  input  logic [1:0]  Jump,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpRegTarget,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Valid,
  input  logic [31:0] IMem_RData,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PC_Plus4_ID,
  output logic        Valid_ID
);

  import fetch_stage_pkg::*;

  fetch_state_t state, next_state;
  logic [31:0]  pc, next_pc, pc_plus4, redirect_target;
  logic [31:0]  hold_buf, load_data;
  logic         deliver, capture;

  assign pc_plus4  = pc + 32'd4;
  assign IMem_Addr = pc;

  always_comb begin
    case (Jump)
      JUMP_JR: redirect_target = JumpRegTarget;
      JUMP_J:  redirect_target = {PC_Plus4_ID[31:28], Instruction_ID[25:0], 2'b00};
      default: redirect_target = PCSource ? BranchTarget : pc_plus4;
    endcase
  end

  // A response landing in WAIT goes straight to IF/ID unless stalled, in
  // which case it is parked in hold_buf until IF/ID can accept it.
  always_comb begin
    next_state = state;
    IMem_Req   = 1'b0;
    deliver    = 1'b0;
    capture    = 1'b0;
    load_data  = IMem_RData;
    case (state)
      ST_RUN: begin
        if (!Flush) begin
          IMem_Req   = Reset_n;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (Flush) begin
          next_state = IMem_Valid ? ST_RUN : ST_DROP;
        end else if (IMem_Valid) begin
          if (IF_ID_Write) begin
            deliver    = 1'b1;
            next_state = ST_RUN;
          end else begin
            capture    = 1'b1;
            next_state = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        load_data = hold_buf;
        if (Flush) begin
          next_state = ST_RUN;
        end else if (IF_ID_Write) begin
          deliver    = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_DROP: begin
        if (IMem_Valid) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    next_pc = pc;
    if (Flush && PC_Write)
      next_pc = redirect_target;
    else if (deliver && PC_Write)
      next_pc = pc_plus4;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= ST_RUN;
      pc       <= RESET_PC;
      hold_buf <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (capture)
        hold_buf <= IMem_RData;
      else if (state == ST_HOLD && next_state == ST_RUN)
        hold_buf <= '0;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (Clk),
    .reset_n     (Reset_n),
    .write_en    (IF_ID_Write),
    .flush       (Flush),
    .load_valid  (deliver),
    .instr_in    (load_data),
    .pc_plus4_in (pc_plus4),
    .instr       (Instruction_ID),
    .pc_plus4    (PC_Plus4_ID),
    .valid       (Valid_ID)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, stall/hold, jump and
// branch redirects, dropped responses, mid-request reset and PC wrap.
module tb_fetch_stage;

  logic        Clk;
  logic        Reset_n;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        Flush;
  logic        PCSource;
  logic [1:0]  Jump;
  logic [31:0] BranchTarget;
  logic [31:0] JumpRegTarget;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Valid;
  logic [31:0] IMem_RData;
  logic [31:0] Instruction_ID;
  logic [31:0] PC_Plus4_ID;
  logic        Valid_ID;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .Flush          (Flush),
    .PCSource       (PCSource),
    .Jump           (Jump),
    .BranchTarget   (BranchTarget),
    .JumpRegTarget  (JumpRegTarget),
    .IMem_Req       (IMem_Req),
    .IMem_Addr      (IMem_Addr),
    .IMem_Valid     (IMem_Valid),
    .IMem_RData     (IMem_RData),
    .Instruction_ID (Instruction_ID),
    .PC_Plus4_ID    (PC_Plus4_ID),
    .Valid_ID       (Valid_ID)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change 1ns after a rising edge; checks run 1ns later still.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; PC_Write = 1'b1; IF_ID_Write = 1'b1; Flush = 1'b0;
    PCSource = 1'b0; Jump = 2'd0; BranchTarget = '0; JumpRegTarget = '0;
    IMem_Valid = 1'b0; IMem_RData = '0;
    step(); step(); settle();
    n_checks++; if (IMem_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %0h expected 0", IMem_Req); end
    n_checks++; if (Valid_ID !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0h expected 0", Valid_ID); end
    n_checks++; if (Instruction_ID !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 00000000", Instruction_ID); end
    n_checks++; if (PC_Plus4_ID !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc4: got %h expected 00000000", PC_Plus4_ID); end
    Reset_n = 1'b1;
    settle();
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_first_req: got req=%0h addr=%h expected req=1 addr=00000000", IMem_Req, IMem_Addr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'(4 * i)) begin n_fail++; $display("[TB] FAIL seq_req%0d: got req=%0h addr=%h expected req=1 addr=%h", i, IMem_Req, IMem_Addr, 32'(4 * i)); end
      step();
      n_checks++; if (IMem_Req !== 1'b0 || Valid_ID !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_wait%0d: got req=%0h valid=%0h expected req=0 valid=0", i, IMem_Req, Valid_ID); end
      IMem_Valid = 1'b1; IMem_RData = 32'hA000_0000 + 32'(i);
      step();
      IMem_Valid = 1'b0;
      settle();
      n_checks++; if (Instruction_ID !== 32'hA000_0000 + 32'(i) || PC_Plus4_ID !== 32'(4 * i + 4) || Valid_ID !== 1'b1)
        begin n_fail++; $display("[TB] FAIL seq_load%0d: got instr=%h pc4=%h valid=%0h expected instr=%h pc4=%h valid=1", i, Instruction_ID, PC_Plus4_ID, Valid_ID, 32'hA000_0000 + 32'(i), 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_stall();
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h8) begin n_fail++; $display("[TB] FAIL stall_req: got req=%0h addr=%h expected req=1 addr=00000008", IMem_Req, IMem_Addr); end
    step();
    IF_ID_Write = 1'b0; PC_Write = 1'b0; IMem_Valid = 1'b1; IMem_RData = 32'hB000_0008;
    step();
    IMem_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (IMem_Req !== 1'b0 || Valid_ID !== 1'b0 || Instruction_ID !== 32'h0)
        begin n_fail++; $display("[TB] FAIL stall_hold%0d: got req=%0h valid=%0h instr=%h expected req=0 valid=0 instr=00000000", i, IMem_Req, Valid_ID, Instruction_ID); end
      if (i < 2) step();
    end
    IF_ID_Write = 1'b1; PC_Write = 1'b1;
    step(); settle();
    n_checks++; if (Instruction_ID !== 32'hB000_0008 || PC_Plus4_ID !== 32'hC || Valid_ID !== 1'b1)
      begin n_fail++; $display("[TB] FAIL stall_release: got instr=%h pc4=%h valid=%0h expected instr=b0000008 pc4=0000000c valid=1", Instruction_ID, PC_Plus4_ID, Valid_ID); end
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'hC) begin n_fail++; $display("[TB] FAIL stall_next_req: got req=%0h addr=%h expected req=1 addr=0000000c", IMem_Req, IMem_Addr); end
  endtask

  task automatic test_jump();
    Flush = 1'b1; Jump = 2'd2; JumpRegTarget = 32'h1000_000C;
    step();
    Flush = 1'b0; Jump = 2'd0;
    settle();
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h1000_000C || Valid_ID !== 1'b0)
      begin n_fail++; $display("[TB] FAIL jr_setup: got req=%0h addr=%h valid=%0h expected req=1 addr=1000000c valid=0", IMem_Req, IMem_Addr, Valid_ID); end
    step();
    IMem_Valid = 1'b1; IMem_RData = 32'h0800_0040;
    step();
    IMem_Valid = 1'b0;
    settle();
    n_checks++; if (Instruction_ID !== 32'h0800_0040 || PC_Plus4_ID !== 32'h1000_0010)
      begin n_fail++; $display("[TB] FAIL j_setup: got instr=%h pc4=%h expected instr=08000040 pc4=10000010", Instruction_ID, PC_Plus4_ID); end
    Flush = 1'b1; Jump = 2'd1;
    settle();
    n_checks++; if (IMem_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL j_flush_noreq: got %0h expected 0", IMem_Req); end
    step();
    Flush = 1'b0; Jump = 2'd0;
    settle();
    n_checks++; if (Valid_ID !== 1'b0 || Instruction_ID !== 32'h0) begin n_fail++; $display("[TB] FAIL j_bubble: got valid=%0h instr=%h expected valid=0 instr=00000000", Valid_ID, Instruction_ID); end
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h1000_0100) begin n_fail++; $display("[TB] FAIL j_target: got req=%0h addr=%h expected req=1 addr=10000100", IMem_Req, IMem_Addr); end
  endtask

  task automatic test_drop();
    step();
    Flush = 1'b1; PCSource = 1'b1; BranchTarget = 32'h200;
    step();
    Flush = 1'b0; PCSource = 1'b0;
    settle();
    n_checks++; if (IMem_Req !== 1'b0 || Valid_ID !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_enter: got req=%0h valid=%0h expected req=0 valid=0", IMem_Req, Valid_ID); end
    step();
    n_checks++; if (IMem_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_wait: got req=%0h expected 0", IMem_Req); end
    IMem_Valid = 1'b1; IMem_RData = 32'hDEAD_BEEF;
    step();
    IMem_Valid = 1'b0;
    settle();
    n_checks++; if (Valid_ID !== 1'b0 || Instruction_ID !== 32'h0) begin n_fail++; $display("[TB] FAIL drop_discard: got valid=%0h instr=%h expected valid=0 instr=00000000", Valid_ID, Instruction_ID); end
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h200) begin n_fail++; $display("[TB] FAIL drop_next_req: got req=%0h addr=%h expected req=1 addr=00000200", IMem_Req, IMem_Addr); end
    step();
    n_checks++; if (Valid_ID !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_wait_valid: got %0h expected 0", Valid_ID); end
    IMem_Valid = 1'b1; IMem_RData = 32'hC000_0200;
    step();
    IMem_Valid = 1'b0;
    settle();
    n_checks++; if (Instruction_ID !== 32'hC000_0200 || PC_Plus4_ID !== 32'h204 || Valid_ID !== 1'b1)
      begin n_fail++; $display("[TB] FAIL drop_branch_load: got instr=%h pc4=%h valid=%0h expected instr=c0000200 pc4=00000204 valid=1", Instruction_ID, PC_Plus4_ID, Valid_ID); end
  endtask

  task automatic test_flush_with_valid();
    step();
    Flush = 1'b1; Jump = 2'd2; JumpRegTarget = 32'h40; IMem_Valid = 1'b1; IMem_RData = 32'hEEEE_0204;
    step();
    Flush = 1'b0; Jump = 2'd0; IMem_Valid = 1'b0;
    settle();
    n_checks++; if (Valid_ID !== 1'b0 || Instruction_ID !== 32'h0) begin n_fail++; $display("[TB] FAIL fv_no_load: got valid=%0h instr=%h expected valid=0 instr=00000000", Valid_ID, Instruction_ID); end
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h40) begin n_fail++; $display("[TB] FAIL fv_redirect: got req=%0h addr=%h expected req=1 addr=00000040", IMem_Req, IMem_Addr); end
  endtask

  task automatic test_reset_mid();
    step();
    Reset_n = 1'b0;
    settle();
    n_checks++; if (IMem_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_req_in_reset: got %0h expected 0", IMem_Req); end
    step();
    IMem_Valid = 1'b1; IMem_RData = 32'hFFFF_0040;
    settle();
    n_checks++; if (IMem_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_req_resp: got %0h expected 0", IMem_Req); end
    step();
    IMem_Valid = 1'b0; Reset_n = 1'b1;
    settle();
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_release_req: got req=%0h addr=%h expected req=1 addr=00000000", IMem_Req, IMem_Addr); end
    n_checks++; if (Valid_ID !== 1'b0 || Instruction_ID !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_ifid: got valid=%0h instr=%h expected valid=0 instr=00000000", Valid_ID, Instruction_ID); end
  endtask

  task automatic test_wrap();
    Flush = 1'b1; Jump = 2'd2; JumpRegTarget = 32'hFFFF_FFFC;
    step();
    Flush = 1'b0; Jump = 2'd0;
    settle();
    n_checks++; if (IMem_Addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", IMem_Addr); end
    step();
    IMem_Valid = 1'b1; IMem_RData = 32'h1234_5678;
    step();
    IMem_Valid = 1'b0;
    settle();
    n_checks++; if (Instruction_ID !== 32'h1234_5678 || PC_Plus4_ID !== 32'h0 || Valid_ID !== 1'b1)
      begin n_fail++; $display("[TB] FAIL wrap_load: got instr=%h pc4=%h valid=%0h expected instr=12345678 pc4=00000000 valid=1", Instruction_ID, PC_Plus4_ID, Valid_ID); end
    n_checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_next_req: got req=%0h addr=%h expected req=1 addr=00000000", IMem_Req, IMem_Addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_drop();
    test_flush_with_valid();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
